// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider, result = a / b.
// The mantissa is divided by a restoring loop, one quotient bit per clock, and
// rounded to nearest-even. Subnormal inputs are read as zero and subnormal
// results are flushed to zero. Valid/ready handshakes on both sides, with one
// operation in flight at a time.
// Optional feature macro: FPDIV_FLAGS_EN adds the registered 5-bit flags port
// {invalid, div_by_zero, overflow, underflow, inexact}.
//
// state    | meaning
// S_IDLE   | in_ready high, operands latched on in_valid
// S_CHECK  | classify operands, set up sign, exponent and mantissas
// S_DIVIDE | MAN_W+3 restoring steps (quotient, guard, round)
// S_ROUND  | round the quotient, or pass the special result, into the result register
// S_DONE   | out_valid high, result held until out_ready
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef FPDIV_FLAGS_EN
  ,
  output logic [4:0]   flags
`endif
);

  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 3);
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic [CW-1:0]        DIV_LAST = CW'(MAN_W + 2);
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIVIDE,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]          a_q, b_q;
  logic                  sign_q;
  logic                  special_q;
  logic [W-1:0]          spec_res_q;
  logic signed [XW-1:0]  exp_q;
  logic [MAN_W+1:0]      rem_q;
  logic [MAN_W:0]        div_q;
  logic [MAN_W+1:0]      quo_q;
  logic [CW-1:0]         cnt_q;

  // operand fields and classes
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sign_c;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign sign_c = a_q[W-1] ^ b_q[W-1];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // special-operand result, first matching rule wins
  logic         spec_hit;
  logic [W-1:0] spec_val;
  always_comb begin
    spec_hit = 1'b1;
    spec_val = '0;
    if (a_nan || b_nan)
      spec_val = QNAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf))
      spec_val = QNAN;
    else if (b_zero || a_inf)
      spec_val = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_inf || a_zero)
      spec_val = {sign_c, {(W-1){1'b0}}};
    else
      spec_hit = 1'b0;
  end

  // normal-path setup: the dividend is pre-shifted when ma < mb so the quotient lands in [1,2)
  logic [MAN_W:0]       ma, mb;
  logic                 ma_lt;
  logic signed [XW-1:0] exp_c;
  assign ma    = {1'b1, fa};
  assign mb    = {1'b1, fb};
  assign ma_lt = ma < mb;
  assign exp_c = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS - (ma_lt ? EXP_ONE : EXP_ZERO);

  // one restoring step; the remainder stays below the divisor, so the shift drops only a zero
  logic             ge;
  logic [MAN_W+1:0] rem_sub;
  assign ge      = rem_q >= {1'b0, div_q};
  assign rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;

  // round-to-nearest-even, then range check on the post-round exponent
  logic                 guard_b, round_b, sticky_b, rnd_up;
  logic [MAN_W:0]       frac_sum;
  logic signed [XW-1:0] exp_r;
  logic                 ovf_c, unf_c;
  logic [W-1:0]         rnd_val;
  assign guard_b  = quo_q[1];
  assign round_b  = quo_q[0];
  assign sticky_b = |rem_q;
  assign rnd_up   = guard_b & (round_b | sticky_b | quo_q[2]);
  assign frac_sum = {1'b0, quo_q[MAN_W+1:2]} + (MAN_W+1)'(rnd_up);
  assign exp_r    = exp_q + (frac_sum[MAN_W] ? EXP_ONE : EXP_ZERO);
  assign ovf_c    = exp_r >= EXP_TOP;
  assign unf_c    = exp_r <= EXP_ZERO;

  // packed rounded result, saturated to inf or flushed to zero
  always_comb begin
    if (ovf_c)
      rnd_val = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf_c)
      rnd_val = {sign_q, {(W-1){1'b0}}};
    else
      rnd_val = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (in_valid) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = spec_hit ? S_ROUND : S_DIVIDE;
      S_DIVIDE: if (cnt_q == '0) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // datapath registers; result is written only in S_ROUND so it stays put through S_DONE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      exp_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        S_CHECK: begin
          sign_q     <= sign_c;
          special_q  <= spec_hit;
          spec_res_q <= spec_val;
          exp_q      <= exp_c;
          rem_q      <= ma_lt ? {ma, 1'b0} : {1'b0, ma};
          div_q      <= mb;
          quo_q      <= '0;
          cnt_q      <= DIV_LAST;
        end
        S_DIVIDE: begin
          rem_q <= rem_sub << 1;
          quo_q <= {quo_q[MAN_W:0], ge};
          cnt_q <= cnt_q - CW'(1);
        end
        S_ROUND: begin
          result <= special_q ? spec_res_q : rnd_val;
        end
        default: ;
      endcase
    end
  end

`ifdef FPDIV_FLAGS_EN
  logic       a_snan, b_snan;
  logic [4:0] spec_flg;
  logic [4:0] spec_flg_q;
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];

  // flags raised by the special-operand rules
  always_comb begin
    spec_flg = '0;
    if (a_nan || b_nan)
      spec_flg[4] = a_snan | b_snan;
    else if ((a_zero && b_zero) || (a_inf && b_inf))
      spec_flg[4] = 1'b1;
    else if (b_zero && !a_inf)
      spec_flg[3] = 1'b1;
  end

  // flags registered alongside result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spec_flg_q <= '0;
      flags      <= '0;
    end else begin
      if (state == S_CHECK)
        spec_flg_q <= spec_flg;
      if (state == S_ROUND)
        flags <= special_q ? spec_flg_q
                           : {2'b00, ovf_c, unf_c, guard_b | round_b | sticky_b | ovf_c | unf_c};
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: randomized and directed checks of fp_div_iter in binary32 and
// binary16 builds against an integer-division reference model.
module tb_fp_div_iter;

  logic        clk;
  logic        rstn;
  logic        iv_s, ir_s, ov_s, ordy_s;
  logic [31:0] a_s, b_s, res_s;
  logic        iv_h, ir_h, ov_h, ordy_h;
  logic [15:0] a_h, b_h, res_h;
`ifdef FPDIV_FLAGS_EN
  logic [4:0]  flg_s, flg_h;
`endif

  int n_tests;
  int n_fail;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut_s (
    .clk(clk), .rstn(rstn),
    .in_valid(iv_s), .in_ready(ir_s), .a(a_s), .b(b_s),
    .out_valid(ov_s), .out_ready(ordy_s), .result(res_s)
`ifdef FPDIV_FLAGS_EN
    , .flags(flg_s)
`endif
  );

  fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rstn(rstn),
    .in_valid(iv_h), .in_ready(ir_h), .a(a_h), .b(b_h),
    .out_valid(ov_h), .out_ready(ordy_h), .result(res_h)
`ifdef FPDIV_FLAGS_EN
    , .flags(flg_h)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient with remainder, rounded to nearest-even.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input int ew, input int mw,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output bit spec);
    longint emax, bias, ea, eb, fa, fb, ma, mb, num, q, rem, keep, rb, half, e, sgn;
    longint qnan, inf_v, zero_v;
    bit an, bn, asn, bsn, ai, bi, az, bz, up, inx;
    int w, sh, s;
    w      = 1 + ew + mw;
    emax   = (longint'(1) << ew) - 1;
    bias   = (longint'(1) << (ew - 1)) - 1;
    ea     = (longint'(a) >> mw) & emax;
    eb     = (longint'(b) >> mw) & emax;
    fa     = longint'(a) & ((longint'(1) << mw) - 1);
    fb     = longint'(b) & ((longint'(1) << mw) - 1);
    sgn    = ((longint'(a) ^ longint'(b)) >> (w - 1)) & 1;
    an     = (ea == emax) && (fa != 0);
    bn     = (eb == emax) && (fb != 0);
    asn    = an && (((fa >> (mw - 1)) & 1) == 0);
    bsn    = bn && (((fb >> (mw - 1)) & 1) == 0);
    ai     = (ea == emax) && (fa == 0);
    bi     = (eb == emax) && (fb == 0);
    az     = (ea == 0);
    bz     = (eb == 0);
    qnan   = (emax << mw) | (longint'(1) << (mw - 1));
    inf_v  = (sgn << (w - 1)) | (emax << mw);
    zero_v = sgn << (w - 1);
    spec   = 1'b1;
    f      = '0;
    r      = '0;
    if (an || bn) begin
      r = 32'(qnan); f[4] = asn || bsn;
    end else if ((az && bz) || (ai && bi)) begin
      r = 32'(qnan); f = 5'b10000;
    end else if (bz && !ai) begin
      r = 32'(inf_v); f = 5'b01000;
    end else if (ai) begin
      r = 32'(inf_v);
    end else if (bi || az) begin
      r = 32'(zero_v);
    end else begin
      spec = 1'b0;
      s    = mw + 3;
      ma   = fa | (longint'(1) << mw);
      mb   = fb | (longint'(1) << mw);
      num  = ma << s;
      q    = num / mb;
      rem  = num % mb;
      e    = ea - eb + bias;
      if (q >= (longint'(1) << s)) sh = 3;
      else begin sh = 2; e = e - 1; end
      keep = q >> sh;
      rb   = q & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (rb != 0) || (rem != 0);
      up   = (rb > half) || ((rb == half) && ((rem != 0) || ((keep & 1) != 0)));
      if (up) keep = keep + 1;
      if (keep == (longint'(1) << (mw + 1))) begin keep = keep >> 1; e = e + 1; end
      if (e >= emax) begin
        r = 32'(inf_v); f = 5'b00101;
      end else if (e <= 0) begin
        r = 32'(zero_v); f = 5'b00011;
      end else begin
        r = 32'((sgn << (w - 1)) | (e << mw) | (keep & ((longint'(1) << mw) - 1)));
        f = {4'b0000, inx};
      end
    end
  endfunction

  function automatic logic [31:0] gen_op(input int ew, input int mw);
    longint emax, e, f, s;
    int k;
    emax = (longint'(1) << ew) - 1;
    k    = $urandom_range(0, 15);
    f    = longint'({$urandom, $urandom}) & ((longint'(1) << mw) - 1);
    s    = longint'($urandom_range(0, 1));
    case (k)
      0:       e = 0;
      1:       e = emax;
      2:       begin e = emax; f = 0; end
      3:       e = 1;
      4:       e = emax - 1;
      5:       e = 2;
      6:       e = emax - 1 - longint'($urandom_range(0, 3));
      default: e = longint'($urandom_range(1, 32'(emax - 1)));
    endcase
    return 32'((s << (ew + mw)) | (e << mw) | f);
  endfunction

  // One full transaction: accept, wait for result (bounded), optional stall, handoff.
  task automatic run_op(input bit h, input logic [31:0] ta, input logic [31:0] tb_,
                        input int stall, output logic [31:0] res,
                        output logic [4:0] flg, output int lat);
    int guard;
    guard = 0;
    while (!(h ? ir_h : ir_s) && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("ready_wait", 32'(guard < 100), 32'd1);
    if (h) begin iv_h = 1'b1; a_h = ta[15:0]; b_h = tb_[15:0]; end
    else   begin iv_s = 1'b1; a_s = ta; b_s = tb_; end
    @(posedge clk); #1;
    if (h) begin iv_h = 1'b0; a_h = 16'($urandom); b_h = 16'($urandom); end
    else   begin iv_s = 1'b0; a_s = $urandom; b_s = $urandom; end
    chk("busy_in_ready", 32'(h ? ir_h : ir_s), 32'd0);
    lat = 0;
    while (!(h ? ov_h : ov_s) && lat < 200) begin
      if (h) begin iv_h = 1'($urandom_range(0, 1)); a_h = 16'($urandom); end
      else   begin iv_s = 1'($urandom_range(0, 1)); a_s = $urandom; end
      @(posedge clk); #1; lat++;
    end
    iv_h = 1'b0;
    iv_s = 1'b0;
    res  = h ? {16'h0000, res_h} : res_s;
    flg  = '0;
`ifdef FPDIV_FLAGS_EN
    flg  = h ? flg_h : flg_s;
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(h ? ov_h : ov_s), 32'd1);
      chk("hold_result", h ? {16'h0000, res_h} : res_s, res);
      chk("hold_in_ready", 32'(h ? ir_h : ir_s), 32'd0);
    end
    if (h) ordy_h = 1'b1; else ordy_s = 1'b1;
    @(posedge clk); #1;
    ordy_h = 1'b0;
    ordy_s = 1'b0;
    chk("handoff_valid", 32'(h ? ov_h : ov_s), 32'd0);
    chk("handoff_in_ready", 32'(h ? ir_h : ir_s), 32'd1);
  endtask

  task automatic dir_test(input string tag, input bit h, input logic [31:0] ta,
                          input logic [31:0] tb_, input int stall, input logic [31:0] exp_res,
                          input int exp_lat, input logic [4:0] exp_flg);
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
    run_op(h, ta, tb_, stall, res, flg, lat);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
`ifdef FPDIV_FLAGS_EN
    chk({tag, "_flags"}, 32'(flg), 32'(exp_flg));
`else
    if (exp_flg != flg) ; // flags port absent in this build
`endif
  endtask

  task automatic rand_test(input bit h);
    logic [31:0] ta, tb_, res, exp_r;
    logic [4:0]  flg, exp_f;
    bit          spec;
    int          lat, ew, mw;
    ew  = h ? 5 : 8;
    mw  = h ? 10 : 23;
    ta  = gen_op(ew, mw);
    tb_ = gen_op(ew, mw);
    ref_div(ta, tb_, ew, mw, exp_r, exp_f, spec);
    run_op(h, ta, tb_, $urandom_range(0, 3), res, flg, lat);
    chk(h ? "rand16_res" : "rand32_res", res, exp_r);
    chk(h ? "rand16_lat" : "rand32_lat", 32'(lat), spec ? 32'd2 : 32'(mw + 5));
`ifdef FPDIV_FLAGS_EN
    chk(h ? "rand16_flags" : "rand32_flags", 32'(flg), 32'(exp_f));
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    iv_s = 1'b0; ordy_s = 1'b0; a_s = '0; b_s = '0;
    iv_h = 1'b0; ordy_h = 1'b0; a_h = '0; b_h = '0;
    #12;
    chk("rst_in_ready", 32'(ir_s), 32'd1);
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    chk("rst_result", res_s, 32'h0);
    chk("rst16_in_ready", 32'(ir_h), 32'd1);
`ifdef FPDIV_FLAGS_EN
    chk("rst_flags", 32'(flg_s), 32'd0);
`endif
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    dir_test("six_by_two", 1'b0, 32'h40C00000, 32'h40000000, 0, 32'h40400000, 28, 5'b00000);
    dir_test("one_third",  1'b0, 32'h3F800000, 32'h40400000, 0, 32'h3EAAAAAB, 28, 5'b00001);
    dir_test("div_zero",   1'b0, 32'h3F800000, 32'h00000000, 0, 32'h7F800000, 2,  5'b01000);
    dir_test("zero_zero",  1'b0, 32'h00000000, 32'h00000000, 0, 32'h7FC00000, 2,  5'b10000);
    dir_test("ovf",        1'b0, 32'h7F7FFFFF, 32'h3F000000, 0, 32'h7F800000, 28, 5'b00101);
    dir_test("unf",        1'b0, 32'h00800000, 32'hC0000000, 0, 32'h80000000, 28, 5'b00011);
    dir_test("snan",       1'b0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 2,  5'b10000);
    dir_test("stall",      1'b0, 32'h40C00000, 32'h40000000, 10, 32'h40400000, 28, 5'b00000);
    dir_test("half_prec",  1'b1, 32'h00003C00, 32'h00004000, 0, 32'h00003800, 15, 5'b00000);

    // reset in the middle of a divide
    iv_s = 1'b1; a_s = 32'h3F800000; b_s = 32'h40400000;
    @(posedge clk); #1;
    iv_s = 1'b0;
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov_s), 32'd0);
    chk("midrst_in_ready", 32'(ir_s), 32'd1);
    chk("midrst_result", res_s, 32'h0);
    #2 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", 32'(ov_s), 32'd0);

    for (int i = 0; i < 200; i++) rand_test(1'b0);
    for (int i = 0; i < 120; i++) rand_test(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
